// File: rtl/div_unit_pkg.sv
// Shared encodings for the EXE-stage divider: FSM states, stall and ready levels, reset level.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic STOP                 = 1'b1;
  localparam logic NOSTOP               = 1'b0;
  localparam logic RST_ENABLE           = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam int   DOUBLE_REG_BUS_W     = 64;

endpackage

// File: rtl/div_abs_fix.sv
// Conditional two's-complement negate; used for operand magnitude and result sign fixup.
module div_abs_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with pipeline stall request.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  div_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]         rem_q, rem_d;
  logic [DATA_W-1:0]         quo_q, quo_d;
  logic [DATA_W-1:0]         dvs_q, dvs_d;
  logic                      negq_q, negq_d;
  logic                      negr_q, negr_d;
  logic [2*DATA_W-1:0]       result_q, result_d;
  logic                      ready_q, ready_d;

  logic                      sign1, sign2;
  logic [DATA_W-1:0]         abs1, abs2;
  logic [DATA_W:0]           shifted, trial;
  logic [DATA_W-1:0]         step_rem, step_quo;
  logic [DATA_W-1:0]         fix_rem, fix_quo;
  logic                      last_step;

  assign sign1 = signed_div_i & opdata1_i[DATA_W-1];
  assign sign2 = signed_div_i & opdata2_i[DATA_W-1];

  div_abs_fix #(.W(DATA_W)) u_abs1 (.data_i(opdata1_i), .neg_i(sign1), .data_o(abs1));
  div_abs_fix #(.W(DATA_W)) u_abs2 (.data_i(opdata2_i), .neg_i(sign2), .data_o(abs2));

  // Remainder is always below the divisor, so a (DATA_W+1)-bit difference
  // has its MSB set exactly when the trial subtraction goes negative.
  assign shifted   = {rem_q, quo_q[DATA_W-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign step_rem  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign step_quo  = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

  div_abs_fix #(.W(DATA_W)) u_fix_quo (.data_i(step_quo), .neg_i(negq_q), .data_o(fix_quo));
  div_abs_fix #(.W(DATA_W)) u_fix_rem (.data_i(step_rem), .neg_i(negr_q), .data_o(fix_rem));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    result_d   = result_q;
    ready_d    = ready_q;
    stallreq_o = NOSTOP;

    unique case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          stallreq_o = STOP;
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
            rem_d   = '0;
            quo_d   = abs1;
            dvs_d   = abs2;
            negq_d  = sign1 ^ sign2;
            negr_d  = sign1;
            cnt_d   = '0;
`ifdef DIV_EARLY_OUT_EN
            if (abs1 < abs2) begin
              state_d  = DIV_END;
              result_d = {opdata1_i, {DATA_W{1'b0}}};
              ready_d  = DIV_RESULT_READY;
            end
`endif
          end
        end
      end

      DIV_ON: begin
        stallreq_o = STOP;
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            result_d = {fix_rem, fix_quo};
            ready_d  = DIV_RESULT_READY;
            state_d  = DIV_END;
          end
        end
      end

      DIV_BYZERO: begin
        stallreq_o = STOP;
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized DIV/DIVU against a magnitude model.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        annul;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst_n    (rst_n),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sgn),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Truncating division on magnitudes; quotient sign = xor of signs, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = mag(s, a);
    mb = mag(s, b);
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int ref_stalls(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(s, a) < mag(s, b)) return 1;
`endif
    return 33;
  endfunction

  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int hold);
    int          stalls;
    logic        done;
    logic [63:0] held;
    @(negedge clk);
    start  = 1'b1;
    annul  = 1'b0;
    sgn    = s;
    op1    = a;
    op2    = b;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ready) begin
        done = 1'b1;
        break;
      end
      if (stallreq) stalls++;
      if (i == 1) begin
        op1 = $urandom;
        op2 = $urandom;
        sgn = ~s;
      end
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_stalls"}, 64'(stalls), 64'(ref_stalls(s, a, b)));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_nostall_end"}, 64'(stallreq), 64'd0);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_result"}, result, held);
      check({tag, "_hold_ready"}, 64'(ready), 64'd1);
      check({tag, "_hold_stall"}, 64'(stallreq), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_drop_ready"}, 64'(ready), 64'd0);
    check({tag, "_drop_stall"}, 64'(stallreq), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    logic        saw_ready;

    rst_n = 1'b0;
    start = 1'b0;
    annul = 1'b0;
    sgn   = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_stall", 64'(stallreq), 64'd0);
    rst_n = 1'b1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0);
    run_div("div_5_0", 1'b1, 32'd5, 32'd0, 64'd0, 0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    run_div("end_hold", 1'b0, 32'd1000, 32'd9, {32'd1, 32'd111}, 5);
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 1);

    // Annul in the 10th ON cycle.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
    saw_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_ready |= ready;
    end
    annul = 1'b1;
    @(negedge clk);
    saw_ready |= ready;
    check("annul_stall", 64'(stallreq), 64'd0);
    check("annul_no_ready", 64'(saw_ready), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    check("annul_idle_ready", 64'(ready), 64'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    // Reset in the 20th ON cycle; result register holds {0,3} beforehand.
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; op1 = 32'hDEAD_BEEF; op2 = 32'd5;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("midrst_result", result, 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_stall", 64'(stallreq), 64'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 30; n++) begin
      s = 1'($urandom);
      a = (($urandom % 4) == 0) ? 32'($urandom % 64) : 32'($urandom);
      case ($urandom % 8)
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom % 16) + 32'd1;
        3:       b = 32'hFFFF_FFFF - 32'($urandom % 4);
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", n), s, a, b, ref_div(s, a, b), n % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
